// File: rtl/core_pkg.sv
// Shared core definitions: default widths, reset PC and the next-PC source
// selector used by the fetch controller.
package core_pkg;

  localparam int XLEN_DEF     = 16;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_LOOP,
    SRC_JMP,
    SRC_RET,
    SRC_HOLD
  } next_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. Pushing onto a full stack overwrites the oldest
// entry, so the newest RAS_DEPTH return addresses always survive.
module ras_stack #(
  parameter int XLEN      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [XLEN-1:0] i_push_data,
  output logic [XLEN-1:0] o_top,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_ovf,
  output logic            o_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic [PTR_W-1:0] w_push_ptr;

  assign w_push_ptr = r_ptr + PTR_W'(1);
  assign o_top      = r_mem[r_ptr];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_MAX);
  assign o_ovf      = r_ovf;
  assign o_unf      = r_unf;

  // Storage carries no reset; only pointer and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_rst) begin
      r_mem[w_push_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (i_push) begin
      r_ptr <= w_push_ptr;
      if (o_full) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (i_pop) begin
      if (o_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_ptr   <= r_ptr - PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl_ras.sv
// Fetch controller: owns the PC register and selects the next PC from branch,
// loop, jump/call, return and sequential sources, backed by a return-address stack.
module fetch_ctrl_ras
  import core_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              JMP_W     = 9,
  parameter int              RAS_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_f,
  input  logic             i_br_taken_e,
  input  logic [XLEN-1:0]  i_br_target_e,
  input  logic             i_loop_taken_d,
  input  logic [XLEN-1:0]  i_loop_target_d,
  input  logic             i_jmp_d,
  input  logic             i_call_d,
  input  logic             i_ret_d,
  input  logic [JMP_W-1:0] i_jmp_field_d,
  input  logic [XLEN-1:0]  i_link_addr_d,
  output logic [XLEN-1:0]  o_pc_out,
  output logic [XLEN-1:0]  o_pc_plus_1,
  output logic             o_redirect_d,
  output logic             o_ras_empty,
  output logic             o_ras_full,
  output logic             o_ras_ovf,
  output logic             o_ras_unf
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_plus_1;
  logic [XLEN-1:0] w_jmp_target;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;
  logic            w_redirect;
  logic            w_push;
  logic            w_pop;
  next_src_e       w_src;

  assign w_pc_plus_1  = r_pc + XLEN'(1);
  assign w_jmp_target = {i_link_addr_d[XLEN-1:JMP_W], i_jmp_field_d};

  // A taken EX branch means everything in decode is wrong-path, so it outranks stall.
  always_comb begin
    w_src = SRC_SEQ;
    if (i_br_taken_e) begin
      w_src = SRC_BR;
    end else if (i_stall_f) begin
      w_src = SRC_HOLD;
    end else if (i_loop_taken_d) begin
      w_src = SRC_LOOP;
    end else if (i_call_d || i_jmp_d) begin
      w_src = SRC_JMP;
    end else if (i_ret_d) begin
      w_src = SRC_RET;
    end
  end

  always_comb begin
    w_next_pc  = w_pc_plus_1;
    w_redirect = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    case (w_src)
      SRC_BR:   w_next_pc = i_br_target_e;
      SRC_HOLD: w_next_pc = r_pc;
      SRC_LOOP: begin
        w_next_pc  = i_loop_target_d;
        w_redirect = 1'b1;
      end
      SRC_JMP: begin
        w_next_pc  = w_jmp_target;
        w_redirect = 1'b1;
        w_push     = i_call_d;
      end
      SRC_RET: begin
        w_next_pc  = w_ras_empty ? w_pc_plus_1 : w_ras_top;
        w_redirect = 1'b1;
        w_pop      = 1'b1;
      end
      default: ;
    endcase
    if (i_rst) begin
      w_redirect = 1'b0;
      w_push     = 1'b0;
      w_pop      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (i_link_addr_d),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (o_ras_full),
    .o_ovf       (o_ras_ovf),
    .o_unf       (o_ras_unf)
  );

  assign o_pc_out     = r_pc;
  assign o_pc_plus_1  = w_pc_plus_1;
  assign o_redirect_d = w_redirect;
  assign o_ras_empty  = w_ras_empty;

endmodule

// File: tb/tb_fetch_ctrl_ras.sv
// Bench for fetch_ctrl_ras: hand-derived vector table for the directed scenarios,
// then random traffic checked against a queue-based model of the fetch rules.
module tb_fetch_ctrl_ras;

  localparam int XLEN      = 16;
  localparam int JMP_W     = 9;
  localparam int RAS_DEPTH = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, stallF, brTakenE, loopTakenD, jmpD, callD, retD;
  logic [15:0] brTargetE, loopTargetD, linkAddrD;
  logic [8:0]  jmpFieldD;
  logic [15:0] pcOut, pcPlus1;
  logic        redirectD, rasEmpty, rasFull, rasOvf, rasUnf;

  always #5 clk = ~clk;

  fetch_ctrl_ras #(
    .XLEN      (XLEN),
    .JMP_W     (JMP_W),
    .RAS_DEPTH (RAS_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall_f       (stallF),
    .i_br_taken_e    (brTakenE),
    .i_br_target_e   (brTargetE),
    .i_loop_taken_d  (loopTakenD),
    .i_loop_target_d (loopTargetD),
    .i_jmp_d         (jmpD),
    .i_call_d        (callD),
    .i_ret_d         (retD),
    .i_jmp_field_d   (jmpFieldD),
    .i_link_addr_d   (linkAddrD),
    .o_pc_out        (pcOut),
    .o_pc_plus_1     (pcPlus1),
    .o_redirect_d    (redirectD),
    .o_ras_empty     (rasEmpty),
    .o_ras_full      (rasFull),
    .o_ras_ovf       (rasOvf),
    .o_ras_unf       (rasUnf)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [15:0] brTarget;
    logic        loop;
    logic [15:0] loopTarget;
    logic        jmp, call, ret;
    logic [8:0]  field;
    logic [15:0] link;
    logic [15:0] expPc;
    logic        expRedirect, expEmpty, expFull, expOvf, expUnf;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   stepNo = 0;

  // Reference model state: the RAS is a plain queue, newest entry at the back.
  logic [15:0] mPc;
  logic [15:0] mRas[$];
  logic        mOvf, mUnf, mRedirect;

  function automatic vec_t mk(input logic r, s, b, input logic [15:0] bt,
                              input logic l, input logic [15:0] lt,
                              input logic j, c, rt, input logic [8:0] f,
                              input logic [15:0] lk, input logic [15:0] pc,
                              input logic rd, e, fu, o, u);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.brTarget = bt;
    v.loop = l; v.loopTarget = lt; v.jmp = j; v.call = c; v.ret = rt;
    v.field = f; v.link = lk; v.expPc = pc; v.expRedirect = rd;
    v.expEmpty = e; v.expFull = fu; v.expOvf = o; v.expUnf = u;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, stepNo, act, exp);
    end
  endtask

  task automatic modelStep(input vec_t v);
    logic [15:0] upperMask;
    upperMask = 16'hFFFF << JMP_W;
    mRedirect = 1'b0;
    if (v.rst) begin
      mPc = RESET_PC;
      mRas.delete();
      mOvf = 1'b0;
      mUnf = 1'b0;
    end else if (v.br) begin
      mPc = v.brTarget;
    end else if (v.stall) begin
      mPc = mPc;
    end else if (v.loop) begin
      mPc = v.loopTarget;
      mRedirect = 1'b1;
    end else if (v.call || v.jmp) begin
      mRedirect = 1'b1;
      if (v.call) begin
        mRas.push_back(v.link);
        if (mRas.size() > RAS_DEPTH) begin
          void'(mRas.pop_front());
          mOvf = 1'b1;
        end
      end
      mPc = (v.link & upperMask) | 16'(v.field);
    end else if (v.ret) begin
      mRedirect = 1'b1;
      if (mRas.size() == 0) begin
        mPc  = mPc + 16'd1;
        mUnf = 1'b1;
      end else begin
        mPc = mRas.pop_back();
      end
    end else begin
      mPc = mPc + 16'd1;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input bit useTable);
    logic expRd;
    rst = v.rst; stallF = v.stall; brTakenE = v.br; brTargetE = v.brTarget;
    loopTakenD = v.loop; loopTargetD = v.loopTarget; jmpD = v.jmp;
    callD = v.call; retD = v.ret; jmpFieldD = v.field; linkAddrD = v.link;
    modelStep(v);
    expRd = useTable ? v.expRedirect : mRedirect;
    @(negedge clk);
    checkOutput("redirect_d", 16'(redirectD), 16'(expRd));
    @(posedge clk);
    #1;
    if (useTable) begin
      checkOutput("pc_out", pcOut, v.expPc);
      checkOutput("pc_plus_1", pcPlus1, v.expPc + 16'd1);
      checkOutput("ras_empty", 16'(rasEmpty), 16'(v.expEmpty));
      checkOutput("ras_full", 16'(rasFull), 16'(v.expFull));
      checkOutput("ras_ovf", 16'(rasOvf), 16'(v.expOvf));
      checkOutput("ras_unf", 16'(rasUnf), 16'(v.expUnf));
    end else begin
      checkOutput("pc_out", pcOut, mPc);
      checkOutput("pc_plus_1", pcPlus1, mPc + 16'd1);
      checkOutput("ras_empty", 16'(rasEmpty), 16'(mRas.size() == 0));
      checkOutput("ras_full", 16'(rasFull), 16'(mRas.size() == RAS_DEPTH));
      checkOutput("ras_ovf", 16'(rasOvf), 16'(mOvf));
      checkOutput("ras_unf", 16'(rasUnf), 16'(mUnf));
    end
    stepNo++;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; stallF = 0; brTakenE = 0; brTargetE = 0; loopTakenD = 0;
    loopTargetD = 0; jmpD = 0; callD = 0; retD = 0; jmpFieldD = 0; linkAddrD = 0;
    mPc = RESET_PC; mOvf = 0; mUnf = 0; mRedirect = 0;

    //           rst s b brT      l lT       j c r field   link      | pc       rd e f o u
    vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000,0,0,0,9'h000,16'h0000, 16'h0000,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,0,9'h000,16'h0000, 16'h0001,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,0,9'h000,16'h0000, 16'h0002,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,0,9'h000,16'h0000, 16'h0003,0,1,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0000,0,16'h0000,1,0,0,9'h055,16'h1200, 16'h0003,0,1,0,0,0));
    vecs.push_back(mk(0,1,1,16'h0040,0,16'h0000,0,0,0,9'h000,16'h0000, 16'h0040,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h020,16'h0011, 16'h0020,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h020,16'h0021, 16'h0020,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0021,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0011,1,1,0,0,0));
    // Five calls into a four-deep stack, then five returns.
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h030,16'h0001, 16'h0030,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h030,16'h0002, 16'h0030,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h030,16'h0003, 16'h0030,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h030,16'h0004, 16'h0030,1,0,1,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h030,16'h0005, 16'h0030,1,0,1,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0005,1,0,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0004,1,0,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0003,1,0,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0002,1,1,0,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0003,1,1,0,1,1));
    // Wrong-path return under a taken branch must leave the two entries alone.
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h010,16'h0077, 16'h0010,1,0,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h010,16'h0088, 16'h0010,1,0,0,1,1));
    vecs.push_back(mk(0,0,1,16'h0100,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0100,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0088,1,0,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,1,9'h000,16'h0000, 16'h0077,1,1,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,1,16'h0ABC,1,0,0,9'h1FF,16'hFFFF, 16'h0ABC,1,1,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,1,0,9'h1FF,16'hAB21, 16'hABFF,1,0,0,1,1));
    vecs.push_back(mk(0,0,1,16'hFFFF,0,16'h0000,0,0,0,9'h000,16'h0000, 16'hFFFF,0,0,0,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,0,9'h000,16'h0000, 16'h0000,0,0,0,1,1));
    vecs.push_back(mk(1,0,0,16'h0000,0,16'h0000,0,1,0,9'h020,16'h0011, 16'h0000,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0,16'h0000,0,0,0,9'h000,16'h0000, 16'h0001,0,1,0,0,0));

    @(posedge clk);
    #1;
    $display("[TB] directed vectors: %0d", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 1'b1);
    end

    $display("[TB] random phase");
    for (int n = 0; n < 2000; n++) begin
      v.rst        = ($urandom_range(63) == 0);
      v.stall      = ($urandom_range(4) == 0);
      v.br         = ($urandom_range(7) == 0);
      v.brTarget   = 16'($urandom);
      v.loop       = ($urandom_range(9) == 0);
      v.loopTarget = 16'($urandom);
      v.jmp        = ($urandom_range(7) == 0);
      v.call       = ($urandom_range(3) == 0);
      v.ret        = ($urandom_range(3) == 0);
      v.field      = 9'($urandom);
      v.link       = 16'($urandom);
      v.expPc = '0; v.expRedirect = 0; v.expEmpty = 0;
      v.expFull = 0; v.expOvf = 0; v.expUnf = 0;
      applyStimulus(v, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl_ras.md
# fetch_ctrl_ras

Parametrised next-generation fetch controller for the pipelined core. It owns the PC register and next-PC selection from sequential, branch (EX), loop (DE), jump, call and return sources. A configurable-depth return-address stack (RAS) replaces the single return register, so nested calls are supported. Sits between instruction memory addressing and the decode stage, and is driven by the hazard unit's stall signal.

## Interface
- XLEN, 16, PC/data width
- JMP_W, 9, jump-immediate field width (< XLEN)
- RAS_DEPTH, 4, RAS entries (power of two, ≥2)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall_f  in  1  hold PC; ignore decode requests
- br_taken_e  in  1  EX-stage branch resolved taken
- br_target_e  in  XLEN  branch target
- loop_taken_d  in  1  DE for-loop back-edge taken
- loop_target_d  in  XLEN  loop target (register value)
- jmp_d  in  1  DE unconditional jump
- call_d  in  1  DE call: jump and push link_addr_d
- ret_d  in  1  DE return: pop RAS, jump to top
- jmp_field_d  in  JMP_W  jump immediate
- link_addr_d  in  XLEN  PC+1 of decode instruction
- pc_out  out  XLEN  current fetch PC (registered)
- pc_plus_1  out  XLEN  pc_out+1, modulo 2^XLEN
- redirect_d  out  1  decode-level redirect accepted this cycle (flush fetch/decode)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH
- ras_ovf  out  1  sticky: push while full
- ras_unf  out  1  sticky: pop while empty

## Operation
- Next-PC priority, highest first:
  1. br_taken_e → br_target_e. Overrides stall_f. All decode requests discarded (wrong path): no push, no pop, redirect_d=0.
  2. stall_f → hold pc_out. Decode requests ignored, no RAS change, redirect_d=0.
  3. loop_taken_d → loop_target_d.
  4. call_d or jmp_d → {link_addr_d[XLEN-1:JMP_W], jmp_field_d}. A call also pushes link_addr_d.
  5. ret_d → RAS top, then pop. When empty: target = pc_plus_1, set ras_unf, count stays 0.
  6. Otherwise → pc_plus_1.
- redirect_d = 1 exactly when rule 3, 4 or 5 selects, including a ret on an empty RAS.
- Decode requests are normally one-hot. If several are asserted, the priority above applies and only the winning request affects the RAS.
- RAS is a circular buffer with a top pointer (log2 RAS_DEPTH bits) and a count (0..RAS_DEPTH).
  - Push when full: overwrite the oldest entry, pointer wraps, count stays RAS_DEPTH, set ras_ovf.
  - Pop after overflow returns the newest entries correctly. The last valid pop empties the stack.
- Sticky flags clear only on rst.
- All adds wrap modulo 2^XLEN (0xFFFF+1 = 0x0000 at XLEN=16).

## Timing
- Reset values: pc_out=RESET_PC, count=0, pointer=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0. RAS contents are don't-care.
- rst asserted mid-operation wins over every request in the same cycle.
- Next-PC logic and redirect_d are combinational from inputs. pc_out updates on the next edge (1-cycle latency).
- RAS push/pop commits at the same edge as the PC update.
- The popped target comes from the pre-edge top entry, with no extra latency.
- ras_empty and ras_full are registered-state decodes, valid the cycle after the edge.

## Structure
- Shared package `core_pkg`: XLEN default, RESET_PC, next-PC source enum (SRC_SEQ, SRC_BR, SRC_LOOP, SRC_JMP, SRC_RET, SRC_HOLD).
- One sub-module, `ras_stack` (params XLEN, RAS_DEPTH; ports clk, rst, push, pop, push_data, top, empty, full, ovf, unf). fetch_ctrl_ras holds the PC register and the priority mux.

## Test plan
- Reset then 3 free cycles → pc_out 0x0000, 0x0001, 0x0002, 0x0003; redirect_d=0.
- stall_f=1 together with jmp_d=1 → PC held, no redirect. Next cycle with br_taken_e=1, target 0x0040, and stall_f=1 → pc_out=0x0040.
- call_d with link 0x0011 and field 0x020, then call_d with link 0x0021, then ret_d twice → PC 0x0020, 0x0020, 0x0021, 0x0011; count 1, 2, 1, 0; ras_empty=1 at the end.
- 5 calls with RAS_DEPTH=4, links 1..5, then 5 rets → targets 5, 4, 3, 2, then the fifth ret falls through to pc_plus_1; ras_ovf=1, ras_unf=1.
- br_taken_e=1 to 0x0100 with ret_d=1 and count 2 → pc_out=0x0100, count still 2, redirect_d=0.
- pc_out=0xFFFF with no requests → next pc_out=0x0000. rst asserted during call_d → pc_out=RESET_PC, count 0, flags 0.
